// File: rtl/voltage_unscale_pkg.sv
// Shared definitions for the display-to-ADC-code inverse scaler: widths, state
// encoding and the scale divisor table that the forward scaler also uses.
package voltage_unscale_pkg;

    localparam int IN_W   = 25;
    localparam int CODE_W = 12;
    localparam int FRAC   = 10;
    localparam int NUM_W  = IN_W + FRAC;
    localparam int DEN_W  = 17;
    localparam int ITER_W = 6;

    localparam logic [CODE_W-1:0] CODE_MAX = 12'd4095;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } unscale_state_t;

    // Display units per ADC full-scale step; indices 5..7 alias the finest range.
    function automatic logic [DEN_W-1:0] k_lookup(input logic [2:0] scale);
        logic [DEN_W-1:0] k;
        case (scale)
            3'd0, 3'd1: k = 17'd100000;
            3'd2:       k = 17'd10000;
            3'd3:       k = 17'd1000;
            default:    k = 17'd100;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/voltage_unscale_if.sv
// Request/response bundle between the trigger-setting logic and the inverse scaler.
interface voltage_unscale_if;
    import voltage_unscale_pkg::*;

    logic              start;
    logic [IN_W-1:0]   val_in;
    logic [2:0]        scale;
    logic              busy;
    logic              done;
    logic [CODE_W-1:0] code_out;
    logic              sat;

    modport master (
        output start, val_in, scale,
        input  busy, done, code_out, sat
    );

    modport slave (
        input  start, val_in, scale,
        output busy, done, code_out, sat
    );

endinterface

// File: rtl/voltage_unscale_serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// done is high during the cycle whose closing edge produces the last quotient bit.
module voltage_unscale_serial_divider
    import voltage_unscale_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quo
);

    logic [NUM_W-1:0]  num_q;
    logic [DEN_W-1:0]  den_q;
    logic [DEN_W-1:0]  rem_q;
    logic [ITER_W-1:0] iter_q;
    logic              active_q;
    logic [NUM_W-1:0]  quo_q;

    // One extra trial bit: the remainder can reach 99999 and must not wrap when doubled.
    logic [DEN_W:0] trial;
    logic [DEN_W:0] diff;
    logic           take;

    assign trial = {rem_q, num_q[NUM_W-1]};
    assign diff  = trial - {1'b0, den_q};
    assign take  = (trial >= {1'b0, den_q});
    assign done  = active_q && (iter_q == '0);
    assign quo   = quo_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            num_q    <= '0;
            den_q    <= '0;
            rem_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
            quo_q    <= '0;
        end else if (start && !active_q) begin
            num_q    <= num;
            den_q    <= den;
            rem_q    <= '0;
            quo_q    <= '0;
            iter_q   <= ITER_W'(NUM_W - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            num_q <= {num_q[NUM_W-2:0], 1'b0};
            rem_q <= take ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
            quo_q <= {quo_q[NUM_W-2:0], take};
            if (iter_q == '0) begin
                active_q <= 1'b0;
            end else begin
                iter_q <= iter_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/voltage_unscale.sv
// Converts a display-unit value back to a 12-bit ADC code: floor(val*1024/K(scale)),
// clamped to 4095, computed serially behind a start/busy/done handshake.
module voltage_unscale
    import voltage_unscale_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    voltage_unscale_if.slave   bus
);

    unscale_state_t state_q, state_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sat_q,  sat_d;
    logic [CODE_W-1:0] code_q, code_d;

    logic              div_start;
    logic              div_done;
    logic [NUM_W-1:0]  quo;
    logic              ovf;

    assign ovf = |quo[NUM_W-1:CODE_W];

    voltage_unscale_serial_divider u_div (
        .CLK   (CLK),
        .RST_N (RST_N),
        .start (div_start),
        .num   ({bus.val_in, {FRAC{1'b0}}}),
        .den   (k_lookup(bus.scale)),
        .done  (div_done),
        .quo   (quo)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            code_q  <= code_d;
        end
    end

    // Operands are captured by the divider only on the IDLE accept edge.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sat_d     = sat_q;
        code_d    = code_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    div_start = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                code_d  = ovf ? CODE_MAX : quo[CODE_W-1:0];
                sat_d   = ovf;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sat      = sat_q;
    assign bus.code_out = code_q;

endmodule

// File: tb/tb_voltage_unscale.sv
// Directed and randomised checks of the inverse voltage scaler against an
// arithmetic floor/clamp model.
module tb_voltage_unscale;
    import voltage_unscale_pkg::*;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    voltage_unscale_if bus ();

    voltage_unscale dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic prev_done = 1'b0;

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (bus.busy && bus.done) begin
                miscompares++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both high", bus.busy, bus.done);
            end
            if (bus.done && prev_done) begin
                miscompares++;
                $display("FAIL done_width: done high for two cycles, required one");
            end
        end
        prev_done = bus.done;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_conv(input logic [2:0] s, input logic [IN_W-1:0] v);
        bus.scale  = s;
        bus.val_in = v;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            lat++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [CODE_W:0] model(input logic [2:0] s, input logic [IN_W-1:0] v);
        longint k;
        longint q;
        case (s)
            3'd0, 3'd1: k = 100000;
            3'd2:       k = 10000;
            3'd3:       k = 1000;
            default:    k = 100;
        endcase
        q = (longint'(v) * 1024) / k;
        if (q > 4095) return {1'b1, 12'd4095};
        return {1'b0, 12'(q)};
    endfunction

    task automatic test_reset();
        RST_N     = 1'b0;
        bus.start = 1'b0;
        bus.val_in = '0;
        bus.scale  = '0;
        tick();
        tick();
        vectors += 4;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        if (bus.code_out !== 12'd0) begin miscompares++; $display("FAIL reset_code: got %0d want 0", bus.code_out); end
        if (bus.sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %0b want 0", bus.sat); end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        int lat;
        bit ok;
        start_conv(3'd4, 25'd50);
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_accept: got %0b want 1", bus.busy); end
        wait_done(lat, ok);
        vectors += 3;
        if (!ok || lat != 36) begin miscompares++; $display("FAIL latency: got %0d (done seen %0b) want 36", lat, ok); end
        if (bus.code_out !== 12'd512) begin miscompares++; $display("FAIL latency_code: got %0d want 512", bus.code_out); end
        if (bus.sat !== 1'b0) begin miscompares++; $display("FAIL latency_sat: got %0b want 0", bus.sat); end
    endtask

    task automatic test_scales();
        logic [2:0]        s_tab [6] = '{3'd2, 3'd3, 3'd6, 3'd1, 3'd4, 3'd0};
        logic [IN_W-1:0]   v_tab [6] = '{25'd10000, 25'd999, 25'd50, 25'd100000, 25'd4000, 25'h1FFFFFF};
        logic [CODE_W-1:0] c_tab [6] = '{12'd1024, 12'd1022, 12'd512, 12'd1024, 12'd4095, 12'd4095};
        logic              t_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            start_conv(s_tab[i], v_tab[i]);
            wait_done(lat, ok);
            vectors += 2;
            if (!ok || bus.code_out !== c_tab[i]) begin
                miscompares++;
                $display("FAIL scale_code[%0d]: scale=%0d val=%0d got %0d want %0d", i, s_tab[i], v_tab[i], bus.code_out, c_tab[i]);
            end
            if (bus.sat !== t_tab[i]) begin
                miscompares++;
                $display("FAIL scale_sat[%0d]: got %0b want %0b", i, bus.sat, t_tab[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit ok;
        int extra;
        start_conv(3'd3, 25'd1000);
        repeat (5) tick();
        bus.val_in = 25'd50;
        bus.scale  = 3'd4;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.val_in = 25'd7;
        wait_done(lat, ok);
        vectors += 2;
        if (!ok || lat != 30) begin miscompares++; $display("FAIL busy_ignore_latency: got %0d want 30", lat); end
        if (bus.code_out !== 12'd1024) begin miscompares++; $display("FAIL busy_ignore_code: got %0d want 1024", bus.code_out); end
        extra = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (bus.done || bus.busy) extra++;
        end
        vectors++;
        if (extra != 0) begin miscompares++; $display("FAIL busy_ignore_queued: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        start_conv(3'd4, 25'd50);
        repeat (35) tick();
        bus.scale  = 3'd2;
        bus.val_in = 25'd10000;
        bus.start  = 1'b1;
        tick();
        vectors += 2;
        if (bus.done !== 1'b1) begin miscompares++; $display("FAIL b2b_first_done: got %0b want 1", bus.done); end
        if (bus.code_out !== 12'd512) begin miscompares++; $display("FAIL b2b_first_code: got %0d want 512", bus.code_out); end
        tick();
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_next: busy got %0b want 1", bus.busy); end
        wait_done(lat, ok);
        vectors += 2;
        if (!ok || lat != 36) begin miscompares++; $display("FAIL b2b_latency: got %0d want 36", lat); end
        if (bus.code_out !== 12'd1024) begin miscompares++; $display("FAIL b2b_second_code: got %0d want 1024", bus.code_out); end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit ok;
        int seen;
        start_conv(3'd4, 25'd4000);
        repeat (19) tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        vectors += 4;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %0b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %0b want 0", bus.done); end
        if (bus.code_out !== 12'd0) begin miscompares++; $display("FAIL abort_code: got %0d want 0", bus.code_out); end
        if (bus.sat !== 1'b0) begin miscompares++; $display("FAIL abort_sat: got %0b want 0", bus.sat); end
        seen = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (bus.done) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        start_conv(3'd3, 25'd1000);
        wait_done(lat, ok);
        vectors++;
        if (!ok || bus.code_out !== 12'd1024) begin miscompares++; $display("FAIL abort_rerun: got %0d want 1024", bus.code_out); end
    endtask

    task automatic test_random();
        logic [2:0]      s;
        logic [IN_W-1:0] v;
        logic [CODE_W:0] exp;
        int lat;
        bit ok;
        for (int i = 0; i < 200; i++) begin
            s = 3'($urandom_range(0, 7));
            v = 25'($urandom) >> $urandom_range(0, 24);
            exp = model(s, v);
            start_conv(s, v);
            wait_done(lat, ok);
            vectors++;
            if (!ok || bus.code_out !== exp[CODE_W-1:0] || bus.sat !== exp[CODE_W]) begin
                miscompares++;
                $display("FAIL random[%0d]: scale=%0d val=%0d got code=%0d sat=%0b want code=%0d sat=%0b",
                         i, s, v, bus.code_out, bus.sat, exp[CODE_W-1:0], exp[CODE_W]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scales();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
